// File: rtl/bit_serializer_tx_if.sv
// Word handshake into the bit serializer: upstream drives in_data/in_valid,
// the serializer answers with in_ready.
interface bit_serializer_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, in_valid, input in_ready);
  modport slave  (input in_data, in_valid, output in_ready);
endinterface

// File: rtl/bit_serializer_tx.sv
// MSB-first parallel-to-serial stage feeding the 101 sequence detector.
// Define SER_PARITY_EN to append an even-parity bit after every word.
module bit_serializer_tx #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  bit_serializer_tx_if.slave  up,
  output logic                out,
  output logic                out_valid,
  output logic                busy
);

  localparam int CW = $clog2(WIDTH);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             last_bit;
  logic             load;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // The LSB cycle (or the parity cycle) is the only slot in which a new word
  // can start without leaving a gap in the stream.
`ifdef SER_PARITY_EN
  assign up.in_ready = !reset && (state_q == ST_IDLE || state_q == ST_PARITY);
`else
  assign up.in_ready = !reset && (state_q == ST_IDLE ||
                                  (state_q == ST_SHIFT && last_bit));
`endif

  assign load = up.in_valid && up.in_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ov_d    = ov_q;
    busy_d  = busy_q;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        out_d  = IDLE_BIT;
        ov_d   = 1'b0;
        busy_d = 1'b0;
      end
      ST_SHIFT: begin
        if (last_bit) begin
`ifdef SER_PARITY_EN
          state_d = ST_PARITY;
          out_d   = par_q;
          ov_d    = 1'b1;
          busy_d  = 1'b1;
`else
          state_d = ST_IDLE;
          out_d   = IDLE_BIT;
          ov_d    = 1'b0;
          busy_d  = 1'b0;
`endif
        end else begin
          out_d   = shreg_q[WIDTH-2];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
`ifdef SER_PARITY_EN
      ST_PARITY: begin
        state_d = ST_IDLE;
        out_d   = IDLE_BIT;
        ov_d    = 1'b0;
        busy_d  = 1'b0;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A load is only possible in IDLE or the final slot of a word, so it
    // simply overrides whatever the state would otherwise do.
    if (load) begin
      state_d = ST_SHIFT;
      out_d   = up.in_data[WIDTH-1];
      shreg_d = up.in_data[WIDTH-2:0];
      cnt_d   = '0;
      ov_d    = 1'b1;
      busy_d  = 1'b1;
`ifdef SER_PARITY_EN
      par_d   = ^up.in_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= IDLE_BIT;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = ov_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bit_serializer_tx.sv
// Self-checking bench for bit_serializer_tx: a bit-queue reference model checked
// every cycle, directed literal stream checks, then randomized traffic.
module tb_bit_serializer_tx;

  localparam int   WIDTH    = 8;
  localparam logic IDLE_BIT = 1'b0;
`ifdef SER_PARITY_EN
  localparam int   PB = 1;
`else
  localparam int   PB = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic out, out_valid, busy;

  bit_serializer_tx_if #(.WIDTH(WIDTH)) bus ();

  bit_serializer_tx #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .up        (bus.slave),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the serial line is a queue of pending bits. A transfer
  // appends the word (and parity) and one bit is shown per cycle.
  logic m_bit   = IDLE_BIT;
  logic m_valid = 1'b0;
  logic live    = 1'b0;
  logic q_pend[$];

  function automatic logic model_ready();
    return !reset && (q_pend.size() == 0);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q_pend.delete();
      m_bit   = IDLE_BIT;
      m_valid = 1'b0;
      live    = 1'b1;
    end else begin
      if (bus.in_valid && model_ready()) begin
        for (int i = WIDTH - 1; i >= 0; i--) q_pend.push_back(bus.in_data[i]);
        if (PB == 1) q_pend.push_back(^bus.in_data);
      end
      if (q_pend.size() > 0) begin
        m_bit   = q_pend.pop_front();
        m_valid = 1'b1;
      end else begin
        m_bit   = IDLE_BIT;
        m_valid = 1'b0;
      end
    end
  end

  // Compare process plus a record of the observed stream for literal checks.
  logic seen[$];
  logic rdy_s = 1'b0;

  always @(negedge clk) begin
    rdy_s = bus.in_ready;
    if (live) begin
      check("out",       out,          m_bit);
      check("out_valid", out_valid,    m_valid);
      check("busy",      busy,         m_valid);
      check("in_ready",  bus.in_ready, model_ready());
      if (out_valid) seen.push_back(out);
    end
  end

  function automatic logic [63:0] seen_bits();
    logic [63:0] v = '0;
    foreach (seen[i]) v = {v[62:0], seen[i]};
    return v;
  endfunction

  task automatic send(input logic [WIDTH-1:0] w);
    logic got = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    check("send_accept", got, 1'b1);
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!out_valid) done = 1'b1;
    end
    check("idle_timeout", done, 1'b1);
  endtask

  task automatic check_stream(input string name, input int len, input logic [63:0] bits);
    check({name, "_len"}, 64'(seen.size()), 64'(len));
    check({name, "_bits"}, seen_bits(), bits);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset.
    repeat (5) @(negedge clk);
    check("idle_out", out, IDLE_BIT);
    check("idle_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Single word.
    seen.delete();
    send(8'hA5);
    wait_idle();
    if (PB == 1) check_stream("a5", 9, 64'b101001010);
    else         check_stream("a5", 8, 64'b10100101);
    @(posedge clk); #1;

    // Back-to-back with in_valid effectively held.
    seen.delete();
    send(8'hA5);
    send(8'hFF);
    wait_idle();
    if (PB == 1) check_stream("a5ff", 18, 64'b101001010_111111110);
    else         check_stream("a5ff", 16, 64'b10100101_11111111);
    @(posedge clk); #1;

    // Offer a word mid-flight: refused until the final slot, then gapless.
    seen.delete();
    send(8'hA5);
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    @(negedge clk);
    check("ready_mid", bus.in_ready, 1'b0);
    send(8'h3C);
    wait_idle();
    if (PB == 1) check_stream("a53c", 18, 64'b101001010_001111000);
    else         check_stream("a53c", 16, 64'b10100101_00111100);
    @(posedge clk); #1;

    // Reset on the 4th bit aborts the word.
    seen.delete();
    send(8'hA5);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_out", out, IDLE_BIT);
    check("rst_ov", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", bus.in_ready, 1'b0);
    check_stream("abort", 4, 64'b1010);
    @(posedge clk); #1 reset = 1'b0;
    seen.delete();
    send(8'h81);
    wait_idle();
    if (PB == 1) check_stream("w81", 9, 64'b100000010);
    else         check_stream("w81", 8, 64'b10000001);
    @(posedge clk); #1;

    // A5 then 01, exercising a parity bit of 1 when enabled.
    seen.delete();
    send(8'hA5);
    send(8'h01);
    wait_idle();
    if (PB == 1) check_stream("a501", 18, 64'b101001010_000000011);
    else         check_stream("a501", 16, 64'b10100101_00000001);
    @(posedge clk); #1;

    // Random traffic with occasional resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      if (bus.in_valid && rdy_s) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = WIDTH'($urandom);
      end else if (!bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 2) == 0);
        bus.in_data  = WIDTH'($urandom);
      end else if ($urandom_range(0, 1) == 0) begin
        bus.in_data = WIDTH'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_serializer_tx.md
Name: bit_serializer_tx

Overview:
- Parallel-to-serial stage directly upstream of the 101 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- The serial bit `out` drives the detector's `in` port.
- Back-to-back words produce a gapless bit stream; idle cycles drive IDLE_BIT.

Parameters:
- WIDTH, 8, data word width in bits, minimum 2.
- IDLE_BIT, 1'b0, value driven on `out` when no data bit is being sent.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  upstream has a word on in_data.
- in_ready  output  1  block can accept a word this cycle (combinational).
- out  output  1  serial bit stream (registered), feeds the detector's `in`.
- out_valid  output  1  `out` carries a data or parity bit (registered).
- busy  output  1  a word is in flight (registered).

Behaviour:
- Reset (sampled at posedge while reset=1):
  - state=IDLE, shift register=0, bit counter=0.
  - out=IDLE_BIT, out_valid=0, busy=0.
  - in_ready forced 0 while reset=1.
  - A reset in mid-word aborts the word. Its remaining bits are discarded and never sent.
- Handshake:
  - A transfer occurs on a posedge where in_valid=1 and in_ready=1.
  - in_data is captured only at the transfer; later changes to it are ignored.
  - in_valid=1 with in_ready=0 produces no capture. Upstream holds its word.
- States:
  - IDLE: in_ready=1. On transfer, go to SHIFT; at that edge out<=in_data[WIDTH-1], out_valid<=1, busy<=1, counter<=0, and the rest of the word goes into the shift register.
  - SHIFT: each posedge advances one bit, counter+1, out<=next bit (MSB-first). in_ready=1 only when counter==WIDTH-1, i.e. while the LSB is on `out`.
    - Counter==WIDTH-1 with a transfer: load the new word exactly as from IDLE. Its MSB follows the old LSB with zero gap; stay in SHIFT.
    - Counter==WIDTH-1 without a transfer: go to IDLE; out<=IDLE_BIT, out_valid<=0, busy<=0.
- Latency: transfer edge to MSB on `out` is one edge (visible the cycle after acceptance).
- Each bit is held for exactly one clock. A word occupies exactly WIDTH consecutive out_valid cycles.
- Counter width is clog2(WIDTH). It never exceeds WIDTH-1 and resets to 0 on every load.
- Throughput: sustained in_valid=1 gives one word per WIDTH cycles with out_valid continuously 1.
- in_valid deasserting mid-word has no effect on the current word.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined:
  - A PARITY state follows the LSB. `out` carries the even-parity bit (XOR of the captured word) for one cycle with out_valid=1 and busy=1.
  - in_ready=1 during PARITY, not during the LSB cycle. Back-to-back loads happen from PARITY.
  - A word occupies WIDTH+1 cycles.
- Undefined: no PARITY state, no parity logic; behaviour as above.

Test Plan:
- Reset then idle 5 cycles -> out=0, out_valid=0, busy=0, in_ready=1 every cycle after reset deasserts.
- Single word 8'hA5, in_valid pulsed one cycle -> out=1,0,1,0,0,1,0,1 on the 8 following cycles with out_valid=1, then out=0, out_valid=0, busy=0.
- Back-to-back 8'hA5 then 8'hFF, in_valid held -> 16 consecutive out_valid cycles, bits 10100101 11111111. in_ready=1 only in the cycle showing A5's LSB.
- in_valid=1 with 8'h3C during cycle 3 of a word -> no capture (in_ready=0). Word accepted at the LSB cycle; 3C bits follow gaplessly.
- reset asserted on 4th bit of 8'hA5 -> next cycle out=IDLE_BIT, out_valid=0, busy=0. After release, 8'h81 serializes cleanly as 10000001.
- SER_PARITY_EN defined, 8'hA5 then 8'h01 -> 1,0,1,0,0,1,0,1,0 then 0,0,0,0,0,0,0,1,1. in_ready=1 only in the parity cycle of a word in flight.
